mult_booth: RTL and testbench

Sequential radix-2 Booth multiplier, WIDTH×WIDTH → 2·WIDTH, signed or unsigned per operation, one Booth step per clock. It is the multiply counterpart of the sequential divider and uses the same start/busy handshake and clock/reset naming, so both units can sit side by side behind the CPU's MULT/MULTU/DIV/DIVU dispatch. The result register holds the last completed product until the next operation completes.

---
 rtl/mult_booth_if.sv | 22 ++
 rtl/mult_booth.sv | 96 +++++++++
 tb/tb_mult_booth.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mult_booth_if.sv
// Start/busy handshake bundle shared by the sequential multiply and divide units.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     z;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, z
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, z
  );
endinterface

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  mult_booth_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   r_state;
  logic signed [WIDTH+1:0]  r_acc;
  logic        [WIDTH:0]    r_q;
  logic                     r_qm1;
  logic signed [WIDTH:0]    r_m;
  logic        [CNT_W-1:0]  r_cnt;
  logic                     r_busy;
  logic                     r_done;
  logic [2*WIDTH-1:0]       r_z;

  logic signed [WIDTH+1:0]  w_m_ext;
  logic signed [WIDTH+1:0]  w_sum;
  logic signed [WIDTH+1:0]  w_acc_nxt;
  logic        [WIDTH:0]    w_q_nxt;
  logic                     w_qm1_nxt;

  // Operands are widened by one bit so unsigned inputs run through the same signed datapath.
  function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
    return $signed({sgn & v[WIDTH-1], v});
  endfunction

  assign w_m_ext = {r_m[WIDTH], r_m};

  always_comb begin
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
    w_acc_nxt = w_sum >>> 1;
    w_q_nxt   = {w_sum[0], r_q[WIDTH:1]};
    w_qm1_nxt = r_q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_m     <= extend(bus.multiplicand, bus.is_signed);
            r_q     <= extend(bus.multiplier, bus.is_signed);
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          // Last step: the product is taken straight from the shifted values.
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_z     <= {w_acc_nxt[WIDTH-2:0], w_q_nxt};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.z    = r_z;

endmodule

// File: tb/tb_mult_booth.sv
// Directed plus random bench for mult_booth against an arithmetic reference product.
module tb_mult_booth;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mult_booth_if #(.WIDTH(32)) bus ();

  mult_booth #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for done with a cycle bound; returns cycles counted from the edge after acceptance.
  task automatic wait_done(output int cyc, output bit stable, output bit busy_ok,
                           input logic [63:0] prev_z, input bit disturb, input logic s);
    cyc = 0; stable = 1'b1; busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.z !== prev_z) stable = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (disturb && cyc == 5) begin
        bus.start        = 1'b1;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.is_signed    = ~s;
      end
      if (disturb && cyc == 6) bus.start = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit disturb, input string tag);
    logic [63:0] exp, prev_z;
    int cyc;
    bit stable, busy_ok;
    exp    = model(a, b, s);
    prev_z = bus.z;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    wait_done(cyc, stable, busy_ok, prev_z, disturb, s);
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_z"}, bus.z, exp);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, "_z_hold"}, 64'(stable), 64'd1);
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int cyc;
    bit stable, busy_ok;
    logic [31:0] corners [6];
    logic [31:0] ra, rb;
    logic        rs;

    corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h0000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;

    bus.start = 1'b0; bus.is_signed = 1'b0;
    bus.multiplicand = '0; bus.multiplier = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_z", bus.z, 64'd0);
    reset = 1'b0;
    tick();

    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "s_7xm2");
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, "s_m7xm2");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_max");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s_minxmin");
    do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, "s_minx1");
    do_op(32'd0, 32'd12345, 1'b1, 1'b0, "zero_a");
    do_op(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, "zero_b");
    do_op(32'd123, 32'hFFFF_FFD3, 1'b1, 1'b1, "ignore_start");

    // Reset in the middle of a run, with a competing start on the same edge.
    bus.multiplicand = 32'd1000; bus.multiplier = 32'd999; bus.is_signed = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_z", bus.z, 64'd0);
    reset = 1'b0;
    tick();
    chk("postrst_idle", 64'(bus.busy), 64'd0);
    do_op(32'd3, 32'd5, 1'b0, 1'b0, "after_rst_3x5");

    // Start held high across two operations.
    bus.multiplicand = 32'd6; bus.multiplier = 32'd7; bus.is_signed = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("b2b_busy0", 64'(bus.busy), 64'd1);
    bus.multiplicand = 32'hFFFF_FFFF; bus.multiplier = 32'd1;
    wait_done(cyc, stable, busy_ok, bus.z, 1'b0, 1'b1);
    chk("b2b_lat1", 64'(cyc), 64'd33);
    chk("b2b_z1", bus.z, model(32'd6, 32'd7, 1'b1));
    chk("b2b_busy_gap", 64'(bus.busy), 64'd0);
    tick();
    chk("b2b_busy1", 64'(bus.busy), 64'd1);
    chk("b2b_done_drop", 64'(bus.done), 64'd0);
    wait_done(cyc, stable, busy_ok, bus.z, 1'b0, 1'b1);
    bus.start = 1'b0;
    chk("b2b_lat2", 64'(cyc), 64'd33);
    chk("b2b_z2", bus.z, model(32'hFFFF_FFFF, 32'd1, 1'b1));
    chk("b2b_hold2", 64'(stable), 64'd1);
    tick();
    chk("b2b_done2_drop", 64'(bus.done), 64'd0);
    chk("b2b_idle", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 20; i++) begin
      ra = (i % 4 == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = (i % 3 == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
